// File: rtl/tdc_trace_capture.sv
// TDC power-trace capture: synchronises the delay-line taps, reduces each sample to a
// Hamming weight, stores DEPTH samples after a delayed trigger and streams them out.
module tdc_trace_capture #(
    parameter int TDC_WIDTH = 128,
    parameter int OUT_WIDTH = 8,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 8,
    parameter int DLY_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TDC_WIDTH-1:0] tdc_raw,
    input  logic                 arm,
    input  logic                 trig,
    input  logic [DLY_W-1:0]     trig_delay,
    output logic [OUT_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 rd_last,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, DRAIN} state_t;

    state_t               state;
    logic [TDC_WIDTH-1:0] s1;
    logic [TDC_WIDTH-1:0] s2;
    logic [OUT_WIDTH-1:0] s3;
    logic [2:0]           trig_pipe;
    logic                 trig_d3;
    logic [DLY_W-1:0]     dly_reg;
    logic [DLY_W-1:0]     dly_cnt;
    logic [ADDR_W-1:0]    wr_addr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic                 start;
    logic                 wr_en;
    logic [OUT_WIDTH-1:0] ram [DEPTH];

    function automatic logic [OUT_WIDTH-1:0] popcount(input logic [TDC_WIDTH-1:0] v);
        logic [OUT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < TDC_WIDTH; i++) begin
            n = n + {{(OUT_WIDTH-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            trig_pipe <= '0;
        end else begin
            s1        <= tdc_raw;
            s2        <= s1;
            s3        <= popcount(s2);
            trig_pipe <= {trig_pipe[1:0], trig};
        end
    end

    assign trig_d3 = trig_pipe[2];

    // Sample 0 is written in the cycle the start condition fires so that it is the
    // popcount of the taps seen exactly trig_delay cycles after trig.
    assign start = ((state == ARMED) && trig_d3 && (dly_reg == '0)) ||
                   ((state == DELAY) && (dly_cnt == '0));
    assign wr_en = start || (state == CAPTURE);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= s3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dly_reg  <= '0;
            dly_cnt  <= '0;
            wr_addr  <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_en) begin
                wr_addr <= wr_addr + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (arm) begin
                        dly_reg <= trig_delay;
                        busy    <= 1'b1;
                        state   <= ARMED;
                    end
                end
                ARMED: begin
                    if (trig_d3) begin
                        if (dly_reg == '0) begin
                            state <= CAPTURE;
                        end else begin
                            dly_cnt <= dly_reg - DLY_W'(1);
                            state   <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    if (dly_cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                end
                CAPTURE: begin
                    if (wr_addr == ADDR_W'(DEPTH - 1)) begin
                        rd_ptr   <= '0;
                        rd_valid <= 1'b0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    // rd_ptr always points at the next sample so a handshake reloads with no bubble.
                    if (rd_valid && rd_ready && rd_last) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else if (!rd_valid || rd_ready) begin
                        rd_data  <= ram[rd_ptr];
                        rd_valid <= 1'b1;
                        rd_last  <= (rd_ptr == ADDR_W'(DEPTH - 1));
                        rd_ptr   <= rd_ptr + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tdc_trace_capture.md
# tdc_trace_capture

Trace-capture stage that consumes the TDC sensor clock produced by the on-chip clock generator. It samples the TDC delay-line thermometer code every cycle and reduces it to a Hamming weight. After an armed trigger from the cipher core and a programmable delay, it records a fixed-length power trace into on-chip RAM. The stored trace is then streamed to the readout logic over a valid/ready interface.

## Interface
- TDC_WIDTH, 128: delay-line taps per sample.
- OUT_WIDTH, 8: popcount width; must satisfy 2^OUT_WIDTH > TDC_WIDTH.
- DEPTH, 256: samples per trace; power of two.
- ADDR_W, 8: log2(DEPTH).
- DLY_W, 16: trigger-delay counter width.

- clk  in  1  sensor sampling clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- tdc_raw  in  TDC_WIDTH  raw delay-line taps; treated as asynchronous.
- arm  in  1  one-cycle pulse; arms capture.
- trig  in  1  cipher-start pulse, synchronous to clk.
- trig_delay  in  DLY_W  cycles between trig and first stored sample; sampled on arm.
- rd_data  out  OUT_WIDTH  trace sample.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts sample.
- rd_last  out  1  marks sample index DEPTH-1.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last sample handshake.

## Operation
- Data pipeline runs unconditionally, 3 stages:
  - S1/S2: two-flop synchroniser on tdc_raw.
  - S3: registered popcount of S2, zero-extended to OUT_WIDTH.
- trig is delayed 3 cycles (trig_d3) so that it aligns with S3.
- FSM states: IDLE, ARMED, DELAY, CAPTURE, DRAIN.
- IDLE:
  - arm=1 latches trig_delay into dly_reg and moves to ARMED.
  - trig is ignored.
- ARMED:
  - trig_d3=1 moves to CAPTURE when dly_reg==0; otherwise loads the down-counter with dly_reg-1 and moves to DELAY.
  - arm is ignored.
- DELAY: the counter decrements each cycle; at 0 the FSM moves to CAPTURE.
- CAPTURE:
  - Writes the S3 output to RAM[wr_addr] each cycle, with wr_addr counting from 0.
  - After writing DEPTH-1, moves to DRAIN. Exactly DEPTH writes occur.
- DRAIN:
  - RAM read is registered and rd_addr increments on each handshake (rd_valid & rd_ready).
  - rd_data/rd_valid hold stable while rd_valid=1 and rd_ready=0.
  - rd_last=1 together with the sample at index DEPTH-1.
  - On the handshake of that sample the FSM moves to IDLE and pulses done.
- Further trig or arm pulses in DELAY, CAPTURE or DRAIN are ignored.
- rst in any state returns the FSM to IDLE immediately:
  - Counters are cleared and pipeline registers are zeroed.
  - RAM contents are not cleared and are never read without a new capture.

## Timing
- Reset values: rd_data=0, rd_valid=0, rd_last=0, busy=0, done=0, all pipeline registers 0.
- Sample alignment: RAM[0] holds popcount(tdc_raw at cycle T+trig_delay), where T is the cycle trig is high in ARMED (taking trig_delay=0 as cycle T). RAM[k] corresponds to cycle T+trig_delay+k.
- busy rises the cycle after the arm pulse and falls the cycle after the final handshake, i.e. the same cycle done is high.
- First rd_valid: 2 cycles after the cycle RAM[DEPTH-1] is written (one cycle for the state change, one for the RAM read).
- Throughput: one sample per cycle while rd_ready=1 is held.
- After a handshake with rd_ready held high, the next rd_valid follows with no bubble. This requires look-ahead read addressing.
- done is high for exactly 1 cycle.

## Test plan
- Reset: hold rst for 3 cycles with arbitrary inputs, then release. All outputs are 0 and busy=0; trig alone never sets busy.
- Basic capture: trig_delay=0, tdc_raw = k ones in the LSBs at trig-relative cycle k (k=0..127, then 128 thereafter), rd_ready=1. The 256 read samples are 0,1,...,127 followed by 128×128, rd_last occurs on the 256th sample, and done pulses once.
- Delay: trig_delay=5, tdc_raw all-ones except all-zeros at cycles T..T+4. All stored samples equal 128, confirming the 5 zero cycles were skipped.
- Backpressure: toggle rd_ready pseudo-randomly at 50%. rd_data never changes while rd_valid=1 and rd_ready=0, and the read-out sequence is identical to the rd_ready=1 case.
- Spurious events: a second trig during CAPTURE and an arm during DRAIN are both ignored, giving exactly 256 samples and one done pulse.
- Mid-operation reset: assert rst at write index 100, then re-arm and re-trigger. The new trace is correct and starts at index 0, and no samples from the aborted capture appear.
